// File: rtl/picorv_axil_master.sv
// PicoRV32 native memory port to AXI4-Lite master bridge.
// Each CPU request is latched in IDLE and becomes exactly one AXI-Lite read or write.
`timescale 1ns/1ps
module picorv_axil_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic                  mem_instr,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [STRB_WIDTH-1:0] mem_wstrb,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_err,
   output logic [7:0]            err_count,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [2:0]            prot_q, prot_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic [1:0]            resp_q, resp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [7:0]            errcnt_q, errcnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         prot_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         resp_q    <= '0;
         rdata_q   <= '0;
         errcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         prot_q    <= prot_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         errcnt_q  <= errcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      prot_d    = prot_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      errcnt_d  = errcnt_q;

      unique case (state_q)
         IDLE: begin
            if (mem_valid) begin
               addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               prot_d  = {mem_instr, 2'b00};
               if (|mem_wstrb) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_ADDR_DATA;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end
         WR_ADDR_DATA: begin
            // AW and W retire independently; leave once neither is still pending.
            if (m_axil_awready) awvalid_d = 1'b0;
            if (m_axil_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (m_axil_bvalid) begin
               resp_d  = m_axil_bresp;
               state_d = DONE;
            end
         end
         RD_ADDR: begin
            if (m_axil_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axil_rvalid) begin
               rdata_d = m_axil_rdata;
               resp_d  = m_axil_rresp;
               state_d = DONE;
            end
         end
         DONE: begin
            if ((resp_q != 2'b00) && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_ready      = (state_q == DONE);
   assign mem_err        = (state_q == DONE) && (resp_q != 2'b00);
   assign mem_rdata      = rdata_q;
   assign err_count      = errcnt_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = prot_q;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = (state_q == WR_RESP);
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = prot_q;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_picorv_axil_master.sv
// Directed bench for picorv_axil_master with a delay-configurable AXI-Lite slave model.
`timescale 1ns/1ps
module tb_picorv_axil_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic [7:0]  err_count;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [31:0] rdata = '0;

   picorv_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err), .err_count(err_count),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
   );

   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   // slave configuration (set by the tests)
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [31:0] rdata_cfg = '0;
   logic [1:0]  resp_cfg = '0;
   int          r_skip = 0;

   // slave bookkeeping
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   int          aw_vc = 0, w_vc = 0, mr_cnt = 0;
   logic [31:0] last_aw = '0, last_w = '0, last_ar = '0;
   logic [3:0]  last_ws = '0;
   logic [2:0]  last_awprot = '0, last_arprot = '0;
   logic [31:0] smem [0:255];

   // Slave decides its outputs at the falling edge; a valid&&ready pair seen here
   // is the handshake that the next rising edge completes.
   always @(negedge clk) begin
      if (aw_hs > b_hs && w_hs > b_hs) begin
         bvalid = (b_cnt >= b_dly);
         b_cnt  = b_cnt + 1;
      end else begin
         bvalid = 1'b0;
         b_cnt  = 0;
      end
      bresp = resp_cfg;
      if (ar_hs > r_hs + r_skip) begin
         rvalid = (r_cnt >= r_dly);
         r_cnt  = r_cnt + 1;
      end else begin
         rvalid = 1'b0;
         r_cnt  = 0;
      end
      rresp = resp_cfg;
      rdata = rdata_cfg;

      awready = awvalid && (aw_cnt >= aw_dly);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= w_dly);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      arready = arvalid && (ar_cnt >= ar_dly);
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;

      if (awvalid) aw_vc = aw_vc + 1;
      if (wvalid)  w_vc  = w_vc + 1;
      if (mem_ready) mr_cnt = mr_cnt + 1;
      if (awvalid && awready) begin aw_hs = aw_hs + 1; last_aw = awaddr; last_awprot = awprot; end
      if (wvalid && wready)   begin w_hs = w_hs + 1; last_w = wdata; last_ws = wstrb; end
      if (arvalid && arready) begin ar_hs = ar_hs + 1; last_ar = araddr; last_arprot = arprot; end
      if (rvalid && rready)   r_hs = r_hs + 1;
      if (bvalid && bready) begin
         b_hs = b_hs + 1;
         for (int b = 0; b < 4; b++)
            if (last_ws[b]) smem[last_aw[9:2]][8*b +: 8] = last_w[8*b +: 8];
      end
   end

   // Issue one request and wait for mem_ready; n = rising edges from request to pulse, -1 on timeout.
   task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic ins, output int n, output logic [31:0] rd, output logic er);
      mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins; mem_valid = 1'b1;
      n = -1; rd = '0; er = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (mem_ready) begin n = i; rd = mem_rdata; er = mem_err; break; end
      end
      mem_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err} !== 7'b0)
         $display("FAIL reset_ctrl: got %b want 0000000", {awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err});
      else passed++;
      total++;
      if ({mem_rdata, err_count} !== 40'h0)
         $display("FAIL reset_data: rdata %h errcnt %0d want 0 0", mem_rdata, err_count);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_write_same_cycle();
      int n, aw0, w0, b0, m0;
      logic [31:0] rd;
      logic er;
      aw_dly = 0; w_dly = 0; b_dly = 0; resp_cfg = 2'b00;
      aw0 = aw_vc; w0 = w_vc; b0 = b_hs; m0 = mr_cnt;
      do_req(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, n, rd, er);
      repeat (2) @(posedge clk);
      #1;
      // zero-wait write: ready in the 4th cycle counting the request cycle
      total++; if (n !== 3) $display("FAIL wr1_latency: got %0d want 3", n); else passed++;
      total++; if (er !== 1'b0) $display("FAIL wr1_err: got %b want 0", er); else passed++;
      total++; if (aw_vc - aw0 !== 1 || w_vc - w0 !== 1)
         $display("FAIL wr1_valid_cycles: aw %0d w %0d want 1 1", aw_vc - aw0, w_vc - w0); else passed++;
      total++; if (mr_cnt - m0 !== 1 || b_hs - b0 !== 1)
         $display("FAIL wr1_pulses: ready %0d b %0d want 1 1", mr_cnt - m0, b_hs - b0); else passed++;
      total++; if (smem[8'h40] !== 32'hDEADBEEF)
         $display("FAIL wr1_mem: got %h want deadbeef", smem[8'h40]); else passed++;
      total++; if (last_aw !== 32'h100 || last_awprot !== 3'b000)
         $display("FAIL wr1_addr: got %h/%b want 00000100/000", last_aw, last_awprot); else passed++;
   endtask

   task automatic test_write_aw_first();
      int n, aw0, w0, b0;
      logic [31:0] rd;
      logic er;
      aw_dly = 0; w_dly = 3; b_dly = 0;
      aw0 = aw_vc; w0 = w_vc; b0 = b_hs;
      do_req(32'h208, 32'hA5A5C3C3, 4'h3, 1'b0, n, rd, er);
      repeat (2) @(posedge clk);
      #1;
      total++; if (n !== 6) $display("FAIL wr2_latency: got %0d want 6", n); else passed++;
      total++; if (aw_vc - aw0 !== 1 || w_vc - w0 !== 4)
         $display("FAIL wr2_valid_cycles: aw %0d w %0d want 1 4", aw_vc - aw0, w_vc - w0); else passed++;
      total++; if (last_ws !== 4'h3) $display("FAIL wr2_wstrb: got %h want 3", last_ws); else passed++;
      total++; if (b_hs - b0 !== 1) $display("FAIL wr2_bcount: got %0d want 1", b_hs - b0); else passed++;
      w_dly = 0;
   endtask

   task automatic test_instr_read();
      int n;
      logic [31:0] rd;
      logic er;
      ar_dly = 0; r_dly = 3; rdata_cfg = 32'h12345678; resp_cfg = 2'b00;
      do_req(32'h106, 32'h0, 4'h0, 1'b1, n, rd, er);
      @(posedge clk); #1;
      total++; if (n !== 6) $display("FAIL rd_latency: got %0d want 6", n); else passed++;
      total++; if (last_ar !== 32'h104) $display("FAIL rd_araddr: got %h want 00000104", last_ar); else passed++;
      total++; if (last_arprot !== 3'b100) $display("FAIL rd_arprot: got %b want 100", last_arprot); else passed++;
      total++; if (rd !== 32'h12345678 || er !== 1'b0)
         $display("FAIL rd_data: got %h err %b want 12345678 0", rd, er); else passed++;
      r_dly = 0;
   endtask

   task automatic test_write_w_first();
      int n, aw0, w0;
      logic [31:0] rd;
      logic er;
      aw_dly = 2; w_dly = 0;
      aw0 = aw_vc; w0 = w_vc;
      do_req(32'h044, 32'h0BADF00D, 4'hC, 1'b0, n, rd, er);
      repeat (2) @(posedge clk);
      #1;
      total++; if (n !== 5) $display("FAIL wr3_latency: got %0d want 5", n); else passed++;
      total++; if (aw_vc - aw0 !== 3 || w_vc - w0 !== 1)
         $display("FAIL wr3_valid_cycles: aw %0d w %0d want 3 1", aw_vc - aw0, w_vc - w0); else passed++;
      total++; if (mem_rdata !== 32'h12345678)
         $display("FAIL wr3_rdata_hold: got %h want 12345678", mem_rdata); else passed++;
      aw_dly = 0;
   endtask

   task automatic test_err_saturate();
      int n;
      logic [31:0] rd;
      logic er;
      r_dly = 0; resp_cfg = 2'b10; rdata_cfg = 32'h0BAD0BAD;
      do_req(32'h010, 32'h0, 4'h0, 1'b0, n, rd, er);
      @(posedge clk); #1;
      total++; if (n !== 3 || er !== 1'b1)
         $display("FAIL err_first: latency %0d err %b want 3 1", n, er); else passed++;
      total++; if (err_count !== 8'd1) $display("FAIL err_count1: got %0d want 1", err_count); else passed++;
      for (int k = 2; k <= 300; k++) begin
         do_req(32'h010, 32'h0, 4'h0, 1'b0, n, rd, er);
         @(posedge clk); #1;
         if (k == 255) begin
            total++; if (err_count !== 8'd255) $display("FAIL err_count255: got %0d want 255", err_count); else passed++;
         end
      end
      total++; if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d want 255", err_count); else passed++;
      total++; if (n !== 3 || er !== 1'b1)
         $display("FAIL err_last: latency %0d err %b want 3 1", n, er); else passed++;
      resp_cfg = 2'b00;
   endtask

   task automatic test_reset_mid_read();
      bit got, saw_rv, bad;
      int m0;
      ar_dly = 0; r_dly = 6; rdata_cfg = 32'hCAFE0001;
      mem_addr = 32'h020; mem_wstrb = 4'h0; mem_instr = 1'b0; mem_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (rready) begin got = 1; break; end
      end
      mem_valid = 1'b0;
      total++; if (!got) $display("FAIL rst_reach_rd_data: got rready 0 want 1"); else passed++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err} !== 7'b0)
         $display("FAIL rst_mid_ctrl: got %b want 0000000", {awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err});
      else passed++;
      total++; if (mem_rdata !== 32'h0 || err_count !== 8'd0)
         $display("FAIL rst_mid_data: rdata %h errcnt %0d want 0 0", mem_rdata, err_count); else passed++;
      m0 = mr_cnt; saw_rv = 0; bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (rvalid) saw_rv = 1;
         if (rready || mem_ready) bad = 1;
      end
      total++; if (!saw_rv || bad)
         $display("FAIL rst_late_rvalid: saw_rvalid %0d rready_or_ready %0d want 1 0", saw_rv, bad); else passed++;
      total++; if (mr_cnt != m0) $display("FAIL rst_no_ready: got %0d pulses want 0", mr_cnt - m0); else passed++;
      r_skip = r_skip + 1;
      r_dly = 0;
      @(posedge clk); @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n1, ar_at, rdy_at, aw0, ar0, m0, awv0;
      aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; resp_cfg = 2'b00; rdata_cfg = 32'h5555AAAA;
      aw0 = aw_hs; ar0 = ar_hs; m0 = mr_cnt; awv0 = aw_vc;
      mem_addr = 32'h200; mem_wdata = 32'h11; mem_wstrb = 4'hF; mem_instr = 1'b0; mem_valid = 1'b1;
      n1 = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (mem_ready) begin n1 = i; break; end
      end
      mem_addr = 32'h300; mem_wstrb = 4'h0;
      ar_at = -1; rdy_at = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (arvalid && ar_at < 0) ar_at = i;
         if (mem_ready && rdy_at < 0) begin rdy_at = i; break; end
      end
      mem_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (n1 !== 3) $display("FAIL b2b_first_latency: got %0d want 3", n1); else passed++;
      total++; if (ar_at !== 2) $display("FAIL b2b_ar_start: got %0d want 2", ar_at); else passed++;
      total++; if (rdy_at !== 4) $display("FAIL b2b_second_ready: got %0d want 4", rdy_at); else passed++;
      total++; if (aw_hs - aw0 !== 1 || aw_vc - awv0 !== 1)
         $display("FAIL b2b_no_dup_write: aw_hs %0d aw_cycles %0d want 1 1", aw_hs - aw0, aw_vc - awv0); else passed++;
      total++; if (ar_hs - ar0 !== 1 || last_ar !== 32'h300)
         $display("FAIL b2b_read: ar_hs %0d araddr %h want 1 00000300", ar_hs - ar0, last_ar); else passed++;
      total++; if (mr_cnt - m0 !== 2) $display("FAIL b2b_ready_pulses: got %0d want 2", mr_cnt - m0); else passed++;
   endtask

   initial begin
      test_reset();
      test_write_same_cycle();
      test_write_aw_first();
      test_instr_read();
      test_write_w_first();
      test_err_saturate();
      test_reset_mid_read();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
